// File: rtl/ifm_input_sel_ml.sv
// ifm_input_sel_ml: multi-lane IFM input selector.
// Holds one sparsemap window and turns per-lane priority-encoder match
// positions into compressed IFM memory read addresses. The running base
// advances by the window popcount when a window retires, and a snapshot of
// base plus an in-window offset lets the next chunk resume mid-stream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_EMPTY   | no window held; ready for a new one, matches are ignored
// ST_LOADED  | window held in smap_q; matches translate to read addresses
module ifm_input_sel_ml #(
    parameter int MEM_SIZE  = 128,
    parameter int PS_SIZE   = 32,
    parameter int NUM_LANES = 2,
    localparam int AW = $clog2(MEM_SIZE) + 1,
    localparam int SW = (MEM_SIZE / PS_SIZE > 1) ? $clog2(MEM_SIZE / PS_SIZE) : 1,
    localparam int PW = $clog2(PS_SIZE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     chunk_start_i,
    input  logic                     smap_valid_i,
    output logic                     smap_ready_o,
    input  logic [PS_SIZE-1:0]       smap_i,
    input  logic [SW-1:0]            smap_last_idx_i,
    input  logic [SW-1:0]            step_idx_i,
    input  logic [PW-1:0]            shift_i,
    input  logic [NUM_LANES-1:0]     match_valid_i,
    input  logic [NUM_LANES*PW-1:0]  match_pos_i,
    input  logic                     pri_enc_end_i,
    output logic [NUM_LANES-1:0]     rd_valid_o,
    output logic [NUM_LANES*AW-1:0]  rd_addr_o,
    output logic [SW-1:0]            win_idx_o,
    output logic                     ovf_o
);

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [PS_SIZE-1:0]      smap_q;
    logic [AW-1:0]           base_q;
    logic [AW-1:0]           snap_q;
    logic [SW-1:0]           win_idx_q;
    logic                    ovf_q;
    logic [NUM_LANES-1:0]    rd_valid_q;
    logic [NUM_LANES*AW-1:0] rd_addr_q;

    logic                    loaded;
    logic                    ready;
    logic                    accept;
    logic                    retire;
    logic                    last_win;
    logic [AW-1:0]           pop;
    logic [AW-1:0]           snap_ofs;
    logic [AW:0]             advance_sum;
    logic [AW-1:0]           lane_addr [NUM_LANES];

    // Number of set bits of w strictly below position k (k may equal PS_SIZE
    // to obtain the full popcount).
    function automatic logic [AW-1:0] ones_below(input logic [PS_SIZE-1:0] w,
                                                 input logic [PW:0]        k);
        logic [AW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PS_SIZE; i++) begin
            if ((PW+1)'(i) < k) begin
                cnt = cnt + AW'(w[i]);
            end
        end
        return cnt;
    endfunction

    // Handshake and next state; a retiring window can be replaced in the
    // same cycle, so ready follows pri_enc_end_i combinationally.
    always_comb begin
        loaded  = (state_q == ST_LOADED);
        ready   = !loaded || pri_enc_end_i;
        accept  = smap_valid_i && ready;
        state_d = state_q;
        if (loaded && (chunk_start_i || pri_enc_end_i)) begin
            state_d = ST_EMPTY;
        end
        if (accept) begin
            state_d = ST_LOADED;
        end
    end

    // Window arithmetic: popcount, snapshot offset and per-lane addresses.
    always_comb begin
        retire      = loaded && pri_enc_end_i && !chunk_start_i;
        last_win    = (win_idx_q == smap_last_idx_i);
        pop         = ones_below(smap_q, (PW+1)'(PS_SIZE));
        snap_ofs    = ones_below(smap_q, {1'b0, shift_i});
        advance_sum = {1'b0, base_q} + {1'b0, pop};
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_addr[l] = base_q + ones_below(smap_q, {1'b0, match_pos_i[l*PW +: PW]});
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Held sparsemap window, captured on every accepted handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            smap_q <= '0;
        end else if (accept) begin
            smap_q <= smap_i;
        end
    end

    // Running base, window index and sticky overflow; a chunk start
    // outranks a retire in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q    <= '0;
            win_idx_q <= '0;
            ovf_q     <= 1'b0;
        end else if (chunk_start_i) begin
            base_q    <= (step_idx_i != '0) ? snap_q : '0;
            win_idx_q <= '0;
        end else if (retire) begin
            if (last_win) begin
                base_q    <= '0;
                win_idx_q <= '0;
            end else begin
                base_q    <= advance_sum[AW-1:0];
                win_idx_q <= win_idx_q + SW'(1);
                if (advance_sum > (AW+1)'(MEM_SIZE)) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Resume snapshot, refreshed every cycle the step window is held so the
    // last value before the chunk start is the one that sticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_q <= '0;
        end else if (loaded && (win_idx_q == step_idx_i)) begin
            snap_q <= base_q + snap_ofs;
        end
    end

    // Registered read port; addresses only move when their lane fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                rd_valid_q[l] <= loaded && match_valid_i[l];
                if (loaded && match_valid_i[l]) begin
                    rd_addr_q[l*AW +: AW] <= lane_addr[l];
                end
            end
        end
    end

    assign smap_ready_o = ready;
    assign rd_valid_o   = rd_valid_q;
    assign rd_addr_o    = rd_addr_q;
    assign win_idx_o    = win_idx_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ifm_input_sel_ml.sv
// Bench for ifm_input_sel_ml with 8-bit windows, 4 windows per chunk buffer
// and two lanes: directed vector table, async reset sequence, then random
// traffic against an arithmetic reference model.
module tb_ifm_input_sel_ml;

    localparam int MEM = 32;
    localparam int PS  = 8;
    localparam int NL  = 2;
    localparam int AW  = 6;
    localparam int SW  = 2;
    localparam int PW  = 3;
    localparam int AMOD = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              chunk_start_i;
    logic              smap_valid_i;
    logic              smap_ready_o;
    logic [PS-1:0]     smap_i;
    logic [SW-1:0]     smap_last_idx_i;
    logic [SW-1:0]     step_idx_i;
    logic [PW-1:0]     shift_i;
    logic [NL-1:0]     match_valid_i;
    logic [NL*PW-1:0]  match_pos_i;
    logic              pri_enc_end_i;
    logic [NL-1:0]     rd_valid_o;
    logic [NL*AW-1:0]  rd_addr_o;
    logic [SW-1:0]     win_idx_o;
    logic              ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    ifm_input_sel_ml #(.MEM_SIZE(MEM), .PS_SIZE(PS), .NUM_LANES(NL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .chunk_start_i(chunk_start_i),
        .smap_valid_i(smap_valid_i), .smap_ready_o(smap_ready_o), .smap_i(smap_i),
        .smap_last_idx_i(smap_last_idx_i), .step_idx_i(step_idx_i), .shift_i(shift_i),
        .match_valid_i(match_valid_i), .match_pos_i(match_pos_i),
        .pri_enc_end_i(pri_enc_end_i), .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o),
        .win_idx_o(win_idx_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       cs;
        bit       sv;
        bit [7:0] smap;
        bit [1:0] last;
        bit [1:0] step;
        bit [2:0] shift;
        bit [1:0] mv;
        bit [2:0] p0;
        bit [2:0] p1;
        bit       pe;
        bit       rdy;
        bit [1:0] v;
        bit [5:0] a0;
        bit [5:0] a1;
        bit [1:0] win;
        bit       ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit cs, input bit sv, input bit [7:0] smap, input bit [1:0] last,
                         input bit [1:0] step, input bit [2:0] shift, input bit [1:0] mv,
                         input bit [2:0] p0, input bit [2:0] p1, input bit pe);
        chunk_start_i   = cs;
        smap_valid_i    = sv;
        smap_i          = smap;
        smap_last_idx_i = last;
        step_idx_i      = step;
        shift_i         = shift;
        match_valid_i   = mv;
        match_pos_i     = {p1, p0};
        pri_enc_end_i   = pe;
    endtask

    function automatic int ones_below(input bit [7:0] w, input int k);
        int c = 0;
        for (int i = 0; i < k; i++) c += int'(w[i]);
        return c;
    endfunction

    // reference model state
    bit       m_loaded;
    bit [7:0] m_bits;
    int       m_base, m_snap, m_win;
    bit       m_ovf;

    initial begin
        // cs sv smap last step shift mv p0 p1 pe | rdy v a0 a1 win ovf
        tbl[0]  = '{0,1,8'hB6,3,0,0,0,0,0,0, 1,0,0,0,0,0};
        tbl[1]  = '{0,0,8'h00,3,0,0,3,2,7,0, 0,3,1,4,0,0};
        tbl[2]  = '{0,0,8'h00,3,0,0,0,0,0,1, 1,0,0,0,1,0};
        tbl[3]  = '{0,1,8'hFF,3,0,0,0,0,0,0, 1,0,0,0,1,0};
        tbl[4]  = '{0,0,8'h00,3,0,0,1,0,0,0, 0,1,5,0,1,0};
        tbl[5]  = '{0,0,8'h00,3,0,0,0,0,0,1, 1,0,0,0,2,0};
        tbl[6]  = '{0,1,8'hFF,3,0,0,0,0,0,0, 1,0,0,0,2,0};
        tbl[7]  = '{0,0,8'h00,3,0,0,3,3,0,0, 0,3,16,13,2,0};
        tbl[8]  = '{0,1,8'hFF,2,0,0,0,0,0,1, 1,0,0,0,0,0};
        tbl[9]  = '{0,0,8'h00,3,0,0,3,3,3,0, 0,3,3,3,0,0};
        tbl[10] = '{1,1,8'h3F,3,0,0,1,5,0,1, 1,1,5,0,0,0};
        tbl[11] = '{0,0,8'h00,3,1,4,1,7,0,0, 0,1,6,0,0,0};
        tbl[12] = '{0,1,8'h1F,3,1,4,0,0,0,1, 1,0,0,0,1,0};
        tbl[13] = '{0,0,8'h00,3,1,4,1,4,0,0, 0,1,10,0,1,0};
        tbl[14] = '{1,0,8'h00,3,1,4,0,0,0,0, 0,0,0,0,0,0};
        tbl[15] = '{0,1,8'hFF,3,1,4,0,0,0,0, 1,0,0,0,0,0};
        tbl[16] = '{0,0,8'h00,3,1,4,1,0,0,0, 0,1,10,0,0,0};
        tbl[17] = '{1,0,8'h00,3,0,0,0,0,0,0, 0,0,0,0,0,0};
        tbl[18] = '{0,1,8'hFF,3,0,0,3,1,1,0, 1,0,0,0,0,0};
        tbl[19] = '{0,0,8'h00,3,0,0,2,0,6,0, 0,2,0,6,0,0};
        tbl[20] = '{0,1,8'hFF,3,3,7,0,0,0,1, 1,0,0,0,1,0};
        tbl[21] = '{0,1,8'hFF,3,3,7,0,0,0,1, 1,0,0,0,2,0};
        tbl[22] = '{0,1,8'hFF,3,3,7,0,0,0,1, 1,0,0,0,3,0};
        tbl[23] = '{0,0,8'h00,3,3,7,1,7,0,0, 0,1,31,0,3,0};
        tbl[24] = '{1,1,8'hFF,3,3,7,0,0,0,1, 1,0,0,0,0,0};
        tbl[25] = '{0,0,8'h00,3,3,7,0,0,0,1, 1,0,0,0,1,1};
        tbl[26] = '{0,0,8'h00,3,3,7,0,0,0,0, 1,0,0,0,1,1};

        // reset values
        rst_i = 1'b1;
        drive(0,0,8'h00,3,0,0,0,0,0,0);
        #12;
        check("reset_rd_valid", 32'(rd_valid_o), 0);
        check("reset_rd_addr", 32'(rd_addr_o), 0);
        check("reset_win_idx", 32'(win_idx_o), 0);
        check("reset_ovf", 32'(ovf_o), 0);
        check("reset_ready", 32'(smap_ready_o), 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // directed vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(tbl[i].cs, tbl[i].sv, tbl[i].smap, tbl[i].last, tbl[i].step, tbl[i].shift,
                  tbl[i].mv, tbl[i].p0, tbl[i].p1, tbl[i].pe);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(smap_ready_o), 32'(tbl[i].rdy));
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid_o), 32'(tbl[i].v));
            if (tbl[i].v[0]) check($sformatf("vec%0d_addr0", i), 32'(rd_addr_o[AW-1:0]), 32'(tbl[i].a0));
            if (tbl[i].v[1]) check($sformatf("vec%0d_addr1", i), 32'(rd_addr_o[2*AW-1:AW]), 32'(tbl[i].a1));
            check($sformatf("vec%0d_win_idx", i), 32'(win_idx_o), 32'(tbl[i].win));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_o), 32'(tbl[i].ovf));
        end

        // async reset mid-window with reads in flight; base is 39 here
        @(negedge clk_i);
        drive(0,1,8'hFF,3,3,7,0,0,0,0);
        @(negedge clk_i);
        drive(0,0,8'h00,3,3,7,3,2,2,0);
        @(posedge clk_i);
        #1;
        check("pre_rst_rd_valid", 32'(rd_valid_o), 3);
        check("pre_rst_addr0", 32'(rd_addr_o[AW-1:0]), 41);
        check("pre_rst_ovf", 32'(ovf_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_rd_valid", 32'(rd_valid_o), 0);
        check("async_rst_rd_addr", 32'(rd_addr_o), 0);
        check("async_rst_ovf", 32'(ovf_o), 0);
        check("async_rst_win_idx", 32'(win_idx_o), 0);
        @(negedge clk_i);
        drive(0,0,8'h00,3,0,0,0,0,0,0);
        rst_i = 1'b0;

        // randomized traffic against the reference model
        m_loaded = 0; m_bits = 0; m_base = 0; m_snap = 0; m_win = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit       cs, sv, pe;
            bit [7:0] smap;
            bit [1:0] last, step, mv;
            bit [2:0] shift, p0, p1;
            bit       e_rdy;
            bit [1:0] e_v;
            int       e_a [2];
            int       pos [2];
            int       n_snap, sum;

            cs    = ($urandom_range(0, 15) == 0);
            sv    = $urandom_range(0, 1) == 1;
            pe    = ($urandom_range(0, 2) == 0);
            smap  = 8'($urandom);
            last  = 2'($urandom);
            step  = 2'($urandom);
            shift = 3'($urandom);
            mv    = 2'($urandom);
            p0    = 3'($urandom);
            p1    = 3'($urandom);
            pos[0] = int'(p0);
            pos[1] = int'(p1);

            e_rdy = !m_loaded || pe;
            for (int l = 0; l < NL; l++) begin
                e_v[l] = m_loaded && mv[l];
                e_a[l] = (m_base + ones_below(m_bits, pos[l])) % AMOD;
            end

            n_snap = m_snap;
            if (m_loaded && m_win == int'(step)) n_snap = (m_base + ones_below(m_bits, int'(shift))) % AMOD;
            if (cs) begin
                m_base = (step != 0) ? m_snap : 0;
                m_win  = 0;
            end else if (m_loaded && pe) begin
                if (m_win == int'(last)) begin
                    m_base = 0;
                    m_win  = 0;
                end else begin
                    sum = m_base + ones_below(m_bits, PS);
                    if (sum > MEM) m_ovf = 1;
                    m_base = sum % AMOD;
                    m_win  = (m_win + 1) % 4;
                end
            end
            m_snap = n_snap;
            if (sv && e_rdy) begin
                m_loaded = 1;
                m_bits   = smap;
            end else if (cs || pe) begin
                m_loaded = 0;
            end

            @(negedge clk_i);
            drive(cs, sv, smap, last, step, shift, mv, p0, p1, pe);
            #1;
            check("rnd_ready", 32'(smap_ready_o), 32'(e_rdy));
            @(posedge clk_i);
            #1;
            check("rnd_rd_valid", 32'(rd_valid_o), 32'(e_v));
            for (int l = 0; l < NL; l++) begin
                if (e_v[l]) check($sformatf("rnd_addr%0d", l), 32'(rd_addr_o[l*AW +: AW]), 32'(e_a[l]));
            end
            check("rnd_win_idx", 32'(win_idx_o), 32'(m_win));
            check("rnd_ovf", 32'(ovf_o), 32'(m_ovf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
